// File: rtl/cam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_pkg: shared camera-path FSM type, counter widths and luma helper.
// Rev 1.0
// ---------------------------------------------------------------------------
package cam_pkg;

   localparam int CAM_X_W = 12;
   localparam int CAM_Y_W = 11;

   typedef enum logic [1:0] {
      GFC_IDLE    = 2'd0,
      GFC_WAIT_VS = 2'd1,
      GFC_CAPTURE = 2'd2,
      GFC_DONE    = 2'd3
   } gfc_state_t;

   // Green carries the 6 luma MSBs; replicating its top bits maps 0->0 and 63->255.
   function automatic logic [7:0] rgb565_grey_to_y8(input logic [15:0] rgb);
      logic unused_rb;
      unused_rb = ^{rgb[15:11], rgb[4:0]};
      return {rgb[10:5], rgb[10:9]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cam_pos_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_pos_cnt: vsync/de edge detection, pixel/line counters and window flag.
// Rev 1.0
// ---------------------------------------------------------------------------
module cam_pos_cnt
   import cam_pkg::*;
#(
   parameter int VS_POL = 1,
   parameter int WIN_X0 = 0,
   parameter int WIN_Y0 = 0,
   parameter int WIN_W  = 28,
   parameter int WIN_H  = 28
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic               vsync_i,
   input  logic               de_i,
   output logic               vs_edge_o,
   output logic [CAM_X_W-1:0] x_cnt_o,
   output logic [CAM_Y_W-1:0] y_cnt_o,
   output logic               in_win_o
);

   localparam logic               c_VS_ACT = (VS_POL != 0);
   localparam logic [CAM_X_W-1:0] c_X0     = CAM_X_W'(WIN_X0);
   localparam logic [CAM_Y_W-1:0] c_Y0     = CAM_Y_W'(WIN_Y0);
   localparam logic [CAM_X_W-1:0] c_WW     = CAM_X_W'(WIN_W);
   localparam logic [CAM_Y_W-1:0] c_WH     = CAM_Y_W'(WIN_H);

   logic               vs_q;
   logic               de_q;
   logic [CAM_X_W-1:0] x_cnt_q, x_cnt_d;
   logic [CAM_Y_W-1:0] y_cnt_q, y_cnt_d;
   logic [CAM_X_W-1:0] w_x_rel;
   logic [CAM_Y_W-1:0] w_y_rel;

   assign vs_edge_o = (vsync_i == c_VS_ACT) && (vs_q != c_VS_ACT);

   always_comb begin
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      if (clr_i) begin
         x_cnt_d = '0;
         y_cnt_d = '0;
      end else if (en_i) begin
         if (de_i) begin
            x_cnt_d = x_cnt_q + CAM_X_W'(1);
         end else if (de_q) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + CAM_Y_W'(1);
         end
      end
   end

   // Reset to the active level so a vsync already asserted at reset is not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q    <= c_VS_ACT;
         de_q    <= 1'b0;
         x_cnt_q <= '0;
         y_cnt_q <= '0;
      end else begin
         vs_q    <= vsync_i;
         de_q    <= de_i;
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
      end
   end

   // Offset subtraction wraps below the origin, so one unsigned compare covers both bounds.
   assign w_x_rel  = x_cnt_q - c_X0;
   assign w_y_rel  = y_cnt_q - c_Y0;
   assign in_win_o = (w_x_rel < c_WW) && (w_y_rel < c_WH);
   assign x_cnt_o  = x_cnt_q;
   assign y_cnt_o  = y_cnt_q;

endmodule
`default_nettype wire

// File: rtl/gray_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gray_frame_ctrl: arms on start, crops one frame window into the CNN buffer.
// Optional build macro GRAY_FRAME_CTRL_BINARIZE_EN thresholds luma at THRESH. Rev 1.0
// ---------------------------------------------------------------------------
module gray_frame_ctrl
   import cam_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int WIN_X0 = 0,
   parameter int WIN_Y0 = 0,
   parameter int WIN_W  = 28,
   parameter int WIN_H  = 28,
   parameter int VS_POL = 1,
   parameter int THRESH = 128
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           in_vsync,
   input  logic                           in_hsync,
   input  logic                           in_de,
   input  logic [15:0]                    in_rgb,
   output logic                           wr_en,
   output logic [$clog2(WIN_W*WIN_H)-1:0] wr_addr,
   output logic [7:0]                     wr_data,
   output logic                           busy,
   output logic                           done,
   output logic                           frame_err
);

   localparam int               c_AW        = $clog2(WIN_W*WIN_H);
   localparam logic [c_AW-1:0]  c_LAST_ADDR = c_AW'(WIN_W*WIN_H - 1);

   if ((WIN_X0 + WIN_W > IMG_W) || (WIN_Y0 + WIN_H > IMG_H)) begin : g_win_illegal
      $error("gray_frame_ctrl: crop window exceeds the active image");
   end
   if ((THRESH < 0) || (THRESH > 255)) begin : g_thresh_illegal
      $error("gray_frame_ctrl: THRESH must fit in 8 bits");
   end

   gfc_state_t         state_q, state_d;
   logic               err_d;
   logic               err_q, done_q, busy_q;
   logic               wr_en_q, last_q;
   logic [c_AW-1:0]    wr_addr_q, addr_cnt_q;
   logic [7:0]         wr_data_q;

   logic               w_vs_edge, w_in_win, w_cnt_clr, w_cnt_en, w_hit;
   logic [CAM_X_W-1:0] w_x_cnt;
   logic [CAM_Y_W-1:0] w_y_cnt;
   logic [7:0]         w_y8, w_pix;
   logic               unused_pos;

   assign w_cnt_clr  = (state_q == GFC_WAIT_VS) && w_vs_edge;
   assign w_cnt_en   = (state_q == GFC_CAPTURE);
   assign unused_pos = ^{in_hsync, w_x_cnt, w_y_cnt};

   cam_pos_cnt #(
      .VS_POL (VS_POL),
      .WIN_X0 (WIN_X0),
      .WIN_Y0 (WIN_Y0),
      .WIN_W  (WIN_W),
      .WIN_H  (WIN_H)
   ) u_pos (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (w_cnt_clr),
      .en_i      (w_cnt_en),
      .vsync_i   (in_vsync),
      .de_i      (in_de),
      .vs_edge_o (w_vs_edge),
      .x_cnt_o   (w_x_cnt),
      .y_cnt_o   (w_y_cnt),
      .in_win_o  (w_in_win)
   );

   // last_q marks the final write in flight; nothing further may be written behind it.
   assign w_hit = w_cnt_en && in_de && w_in_win && !last_q && !w_vs_edge;

   assign w_y8 = rgb565_grey_to_y8(in_rgb);
`ifdef GRAY_FRAME_CTRL_BINARIZE_EN
   assign w_pix = (w_y8 >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
   assign w_pix = w_y8;
`endif

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         GFC_IDLE: begin
            if (start) state_d = GFC_WAIT_VS;
         end
         GFC_WAIT_VS: begin
            if (abort)          state_d = GFC_IDLE;
            else if (w_vs_edge) state_d = GFC_CAPTURE;
         end
         GFC_CAPTURE: begin
            if (abort) begin
               state_d = GFC_IDLE;
               err_d   = 1'b1;
            end else if (last_q) begin
               state_d = GFC_DONE;
            end else if (w_vs_edge) begin
               state_d = GFC_IDLE;
               err_d   = 1'b1;
            end
         end
         GFC_DONE: state_d = GFC_IDLE;
         default:  state_d = GFC_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= GFC_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         last_q     <= 1'b0;
         wr_addr_q  <= '0;
         addr_cnt_q <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != GFC_IDLE);
         done_q  <= (state_d == GFC_DONE);
         err_q   <= err_d;
         wr_en_q <= w_hit;
         last_q  <= w_hit && (addr_cnt_q == c_LAST_ADDR);
         if (w_cnt_clr) begin
            wr_addr_q  <= '0;
            addr_cnt_q <= '0;
         end else if (w_hit) begin
            wr_addr_q  <= addr_cnt_q;
            addr_cnt_q <= addr_cnt_q + c_AW'(1);
            wr_data_q  <= w_pix;
         end
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_err = err_q;

endmodule
`default_nettype wire

// File: doc/gray_frame_ctrl.md
# gray_frame_ctrl

Frame-capture sequencer sitting after the RGB565-to-grey converter in the camera path. On request from the CNN side it arms, waits for the next frame start, extracts a fixed crop window from the grey pixel stream, and writes it as 8-bit luma into the CNN input frame buffer, one address per pixel. It owns the capture schedule: frame alignment, pixel/line counting, window gating, completion and error signalling.

## Interface
Parameters:
- `IMG_W`, 640: active pixels per line of incoming video.
- `IMG_H`, 480: active lines per frame.
- `WIN_X0`, 0: first captured column.
- `WIN_Y0`, 0: first captured line.
- `WIN_W`, 28: captured columns.
- `WIN_H`, 28: captured lines.
- `VS_POL`, 1: vsync active level. 1 means frame start is the rising edge.
- `THRESH`, 128: binarize threshold. Used only when `GRAY_FRAME_CTRL_BINARIZE_EN` is defined.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: capture request pulse from CNN control.
- `abort` in 1: cancel the capture in progress.
- `in_vsync` in 1: frame sync from the grey converter.
- `in_hsync` in 1: line sync. Pass-through only, not used for counting.
- `in_de` in 1: pixel valid.
- `in_rgb` in 16: grey pixel, RGB565 with equal channels.
- `wr_en` out 1: frame-buffer write strobe.
- `wr_addr` out `$clog2(WIN_W*WIN_H)`: write address.
- `wr_data` out 8: luma byte.
- `busy` out 1: high from start acceptance until return to IDLE.
- `done` out 1: one-cycle pulse when the window is complete.
- `frame_err` out 1: one-cycle pulse when the frame is truncated or the capture is aborted.

## Operation
- FSM states: IDLE, WAIT_VS, CAPTURE, DONE.
- IDLE: `start`=1 moves to WAIT_VS. `start` is ignored in every other state.
- WAIT_VS: waits for the active edge of vsync (`VS_POL`). On that edge it clears `x_cnt`, `y_cnt` and `wr_addr`, then moves to CAPTURE. `abort` returns to IDLE with no `frame_err`.
- CAPTURE counters:
  - `x_cnt` (12 b) increments on each `in_de`=1 cycle.
  - On the falling edge of `in_de`, `x_cnt` clears and `y_cnt` (11 b) increments.
- A pixel is in-window when `x_cnt` is in [WIN_X0, WIN_X0+WIN_W) and `y_cnt` is in [WIN_Y0, WIN_Y0+WIN_H).
- Each in-window pixel produces one write. `wr_addr` increments after each write, running 0 up to WIN_W*WIN_H-1, raster order.
- Luma reconstruction: `wr_data` = {`in_rgb[10:5]`, `in_rgb[10:9]`}. The green field carries the 6 MSBs. Bit replication maps 0→0 and 63→255.
- Write of address WIN_W*WIN_H-1 moves to DONE. Remaining pixels of the frame are ignored.
- DONE: `done`=1 for one cycle, then IDLE.
- Another active vsync edge in CAPTURE before completion: `frame_err` pulse, go to IDLE, nothing more written.
- `abort` in CAPTURE: `frame_err` pulse, go to IDLE.
- `abort` and the final write in the same cycle: the write is performed, `abort` wins, so the outcome is `frame_err` with no `done`.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: state IDLE, all counters 0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `frame_err`=0.
- All outputs are registered. `wr_en`/`wr_data` follow the qualifying input pixel by 1 cycle.
- `wr_addr` holds the address of the current write while `wr_en`=1.
- Vsync edge detect uses one input register. The first `in_de` pixel after the edge is counted when CAPTURE has been entered in the cycle after the edge.
- Completion timing:
  - `done` asserts 1 cycle after the last `wr_en`.
  - `busy` deasserts 1 cycle after `done`.
  - `start` is accepted again the cycle after `busy` falls.
- `rst_n` asserted mid-capture: immediate return to reset values, no `done`/`frame_err` pulse.
- Window exceeding `IMG_W`/`IMG_H` is illegal. An elaboration-time check raises an error.

## Configuration
- `GRAY_FRAME_CTRL_BINARIZE_EN` defined: `wr_data` = 8'hFF if the reconstructed luma ≥ `THRESH`, else 8'h00. Latency is unchanged.
- Undefined: `wr_data` is the reconstructed luma.

## Structure
- Shared package `cam_pkg`:
  - FSM state enum `gfc_state_t`.
  - Luma reconstruction function `rgb565_grey_to_y8`.
  - Counter width constants `CAM_X_W`=12 and `CAM_Y_W`=11.
- Natural sub-module `cam_pos_cnt`: vsync/de edge detection plus `x_cnt`/`y_cnt` and in-window flag. Reusable by later window-based blocks.

## Test plan
- **Nominal 28x28 at (0,0):** `start`, then one 640x480 frame with pixel value 16'hFFFF. Expect 784 writes, addr 0..783, data 8'hFF, `done` once, `frame_err` never.
- **Offset window:** WIN_X0=100, WIN_Y0=50, pixel = x coordinate in G field. First write data = {100[5:0],100[5:4]} at addr 0. Addr 27 is the last pixel of line 50. Addr 28 is the first pixel of line 51.
- **Start mid-frame:** `start` asserted at line 200. No writes until the next vsync edge, then a full capture.
- **Truncated frame:** vsync edge after 10 window lines. Expect 280 writes, one `frame_err` pulse, no `done`, `busy` low next cycle.
- **Abort during WAIT_VS and CAPTURE:** abort in WAIT_VS gives no error pulse. Abort in CAPTURE gives one `frame_err` pulse. Reset mid-capture gives all outputs 0 and no pulses.
- **With `GRAY_FRAME_CTRL_BINARIZE_EN`, THRESH=128:** G field 31 gives 8'h00; G field 32 gives 8'hFF.
